// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, lock FSM states and the per-axis
// bounce helper used by the moving box generator.
package vga_pkg;

    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    localparam logic [9:0] H_LAST      = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST      = V_TOTAL - 10'd1;
    localparam logic [9:0] H_ACT_START = H_SYNC + H_BP;
    localparam logic [9:0] H_ACT_END   = H_TOTAL - H_FP;
    localparam logic [9:0] V_ACT_START = V_SYNC + V_BP;
    localparam logic [9:0] V_ACT_END   = V_TOTAL - V_FP;

    // Pixels without an h_sync fall before the lock is dropped, minus one.
    localparam logic [9:0] LOCK_MISS_MAX = 10'd1023;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    // One frame of motion on one axis; 11-bit maths so nothing wraps.
    function automatic axis_t axis_move(input axis_t a, input logic [10:0] step,
                                       input logic [10:0] lim);
        axis_t r;
        r = a;
        if (a.dir) begin
            if ({1'b0, a.pos} + step > lim) begin
                r.pos = lim[9:0];
                r.dir = 1'b0;
            end else begin
                r.pos = a.pos + step[9:0];
            end
        end else if ({1'b0, a.pos} < step) begin
            r.pos = 10'd0;
            r.dir = 1'b1;
        end else begin
            r.pos = a.pos - step[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Follows the external driver's syncs: edge detection plus pixel/line
// counters that snap to zero on every h_sync / v_sync fall.
module vga_sync_tracker
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync_i,
    input  logic       v_sync_i,
    output logic [9:0] hcnt_o,
    output logic [9:0] vcnt_o,
    output logic       h_fall_o,
    output logic       v_fall_o,
    output logic       pix_en_o
);

    logic       hs_q, vs_q;
    logic       phase_q, phase_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;

    assign h_fall_o = hs_q & ~h_sync_i;
    assign v_fall_o = vs_q & ~v_sync_i;
    assign pix_en_o = phase_q;
    assign hcnt_o   = hcnt_q;
    assign vcnt_o   = vcnt_q;

    always_comb begin
        phase_d = ~phase_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        if (phase_q) begin
            hcnt_d = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
        end
        if (h_fall_o) begin
            hcnt_d  = 10'd0;
            phase_d = 1'b0;
            vcnt_d  = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
        if (v_fall_o) begin
            vcnt_d = 10'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            phase_q <= 1'b0;
            hcnt_q  <= 10'd0;
            vcnt_q  <= 10'd0;
        end else begin
            hs_q    <= h_sync_i;
            vs_q    <= v_sync_i;
            phase_q <= phase_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

endmodule

// File: rtl/vga_box_gen.sv
// Bouncing square overlay locked to an external VGA driver's syncs.
// Define VGA_BOX_BORDER_EN to also paint a white 1-pixel frame border.
module vga_box_gen
    import vga_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic [2:0] color_sel,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       locked,
    output logic       frame_tick,
    output logic       sync_err
);

    localparam logic [10:0] BS    = 11'(BOX_SIZE);
    localparam logic [10:0] STP   = 11'(STEP);
    localparam logic [10:0] X_LIM = {1'b0, H_ACTIVE} - BS;
    localparam logic [10:0] Y_LIM = {1'b0, V_ACTIVE} - BS;

    logic [9:0]  hcnt, vcnt, px, py;
    logic        h_fall, v_fall, pix_en, timeout;
    logic        h_act, v_act, visible, in_box;
    lock_state_e state_q;
    logic [9:0]  miss_q;
    axis_t       x_q, x_d, y_q, y_d;
    logic [2:0]  col_q, rgb_q, rgb_d;
    logic        locked_q, frame_tick_q, sync_err_q;

    vga_sync_tracker u_tracker (
        .clk      (clk),
        .reset    (reset),
        .h_sync_i (h_sync),
        .v_sync_i (v_sync),
        .hcnt_o   (hcnt),
        .vcnt_o   (vcnt),
        .h_fall_o (h_fall),
        .v_fall_o (v_fall),
        .pix_en_o (pix_en)
    );

    assign timeout = pix_en && (miss_q == LOCK_MISS_MAX);
    assign px      = hcnt - H_ACT_START;
    assign py      = vcnt - V_ACT_START;
    assign h_act   = (hcnt >= H_ACT_START) && (hcnt < H_ACT_END);
    assign v_act   = (vcnt >= V_ACT_START) && (vcnt < V_ACT_END);
    // Raw sync inputs gate the colour so blanking never lags a sync pulse.
    assign visible = (state_q == ST_LOCKED) && h_sync && v_sync && h_act && v_act;
    assign in_box  = ({1'b0, px} >= {1'b0, x_q.pos}) && ({1'b0, px} < {1'b0, x_q.pos} + BS)
                  && ({1'b0, py} >= {1'b0, y_q.pos}) && ({1'b0, py} < {1'b0, y_q.pos} + BS);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (v_fall && state_q == ST_LOCKED) begin
            x_d = axis_move(x_q, STP, X_LIM);
            y_d = axis_move(y_q, STP, Y_LIM);
        end
    end

    always_comb begin
        rgb_d = 3'b000;
        if (visible && in_box) begin
            rgb_d = col_q;
        end
`ifdef VGA_BOX_BORDER_EN
        if (visible && (px == 10'd0 || px == 10'd639 || py == 10'd0 || py == 10'd479)) begin
            rgb_d = 3'b111;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_UNLOCKED;
            locked_q     <= 1'b0;
            miss_q       <= 10'd0;
            x_q          <= {10'd0, 1'b1};
            y_q          <= {10'd0, 1'b1};
            col_q        <= 3'b001;
            rgb_q        <= 3'b000;
            frame_tick_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (v_fall) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (timeout) begin
                        state_q  <= ST_UNLOCKED;
                        locked_q <= 1'b0;
                    end
                end
            endcase
            // Any sync fall proves the driver is alive and restarts the watchdog.
            if (h_fall || v_fall || timeout) begin
                miss_q <= 10'd0;
            end else if (pix_en) begin
                miss_q <= miss_q + 10'd1;
            end
            if (v_fall) begin
                col_q <= color_sel;
            end
            x_q          <= x_d;
            y_q          <= y_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= v_fall;
            sync_err_q   <= (state_q == ST_LOCKED) && h_fall && (hcnt != H_LAST);
        end
    end

    assign red        = rgb_q[2];
    assign green      = rgb_q[1];
    assign blue       = rgb_q[0];
    assign locked     = locked_q;
    assign frame_tick = frame_tick_q;
    assign sync_err   = sync_err_q;

endmodule
